// File: rtl/vxc_muladd_seq_if.sv
// vxc_muladd_seq_if: control, row-read and result-write signals of the vector mul-add sequencer.
interface vxc_muladd_seq_if #(
    parameter int NI = 8,
    parameter int EW = 32,
    parameter int AW = 1
);
    logic               start;
    logic [1:0]         op;
    logic [EW-1:0]      constant;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [NI*EW-1:0]   first_row;
    logic [NI*EW-1:0]   second_row;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [NI*EW-1:0]   wr_data;
    logic               wr_ready;
    logic               busy;
    logic               finish;
    logic [AW:0]        blk_count;
    modport master (
        output start, op, constant, first_row, second_row, wr_ready,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, finish, blk_count
    );
    modport slave (
        input  start, op, constant, first_row, second_row, wr_ready,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, finish, blk_count
    );
endinterface

// File: rtl/vxc_muladd_seq.sv
// vxc_muladd_seq: block-sequential vector a+b / a+c*b / a-c*b / c*b over NI lanes per block.
module vxc_muladd_seq #(
    parameter int NUM_EQ   = 16,
    parameter int NI       = 8,
    parameter int EW       = 32,
    parameter int RD_LAT   = 2,
    parameter int CALC_LAT = 2
) (
    input logic              clk,
    input logic              reset,
    vxc_muladd_seq_if.slave  bus
);
    localparam int NBLK = (NUM_EQ + NI - 1) / NI;
    localparam int AW   = NBLK > 1 ? $clog2(NBLK) : 1;

    typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [EW-1:0]      c_q, c_d;
    logic [AW-1:0]      blk_q, blk_d;
    logic [AW:0]        blk_count_q, blk_count_d;
    logic [NI*EW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, res;
    logic               last_blk;

    assign last_blk = blk_q == AW'(NBLK - 1);

    // Lanes past the end of the vector are forced to zero in the final block.
    for (genvar i = 0; i < NI; i++) begin : g_lane
        logic [EW-1:0] a, b, p;
        assign a = a_q[i*EW +: EW];
        assign b = b_q[i*EW +: EW];
        assign p = c_q * b;
        assign res[i*EW +: EW] = (int'(blk_q) * NI + i >= NUM_EQ) ? '0 :
                                 op_q == 2'd0 ? a + b :
                                 op_q == 2'd1 ? a + p :
                                 op_q == 2'd2 ? a - p : p;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        c_d         = c_q;
        blk_d       = blk_q;
        blk_count_d = blk_count_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                state_d     = READ;
                op_d        = bus.op;
                c_d         = bus.constant;
                blk_d       = '0;
                blk_count_d = '0;
            end
            READ: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (cnt_q == 3'(RD_LAT - 1)) begin
                state_d = CALC;
                cnt_d   = '0;
                a_d     = bus.first_row;
                b_d     = bus.second_row;
            end else cnt_d = cnt_q + 3'd1;
            CALC: if (cnt_q == 3'(CALC_LAT - 1)) begin
                state_d = WRITE;
                res_d   = res;
            end else cnt_d = cnt_q + 3'd1;
            WRITE: if (bus.wr_ready) begin
                blk_count_d = blk_count_q + 1'b1;
                state_d     = last_blk ? DONE : READ;
                blk_d       = last_blk ? blk_q : blk_q + 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            c_q         <= '0;
            blk_q       <= '0;
            blk_count_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            c_q         <= c_d;
            blk_q       <= blk_d;
            blk_count_q <= blk_count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
        end
    end

    // A write request is withdrawn while reset is asserted so no half-finished transfer lands.
    assign bus.rd_en     = state_q == READ;
    assign bus.rd_addr   = blk_q;
    assign bus.wr_en     = state_q == WRITE && !reset;
    assign bus.wr_addr   = blk_q;
    assign bus.wr_data   = res_q;
    assign bus.busy      = state_q inside {READ, WAIT, CALC, WRITE};
    assign bus.finish    = state_q == DONE;
    assign bus.blk_count = blk_count_q;
endmodule

// File: tb/tb_vxc_muladd_seq.sv
// tb_vxc_muladd_seq: two sequencers (16 and 12 elements) driven in lockstep against a lane-level reference model.
module tb_vxc_muladd_seq;
    localparam int NI = 8, EW = 32, RD_LAT = 2, CALC_LAT = 2, NBLK = 2, AW = 1, W = NI * EW;

    logic clk = 0, reset = 1;
    always #5 clk = ~clk;

    vxc_muladd_seq_if #(.NI(NI), .EW(EW), .AW(AW)) b16(), b12();

    vxc_muladd_seq #(.NUM_EQ(16), .NI(NI), .EW(EW), .RD_LAT(RD_LAT), .CALC_LAT(CALC_LAT))
        dut16 (.clk(clk), .reset(reset), .bus(b16.slave));
    vxc_muladd_seq #(.NUM_EQ(12), .NI(NI), .EW(EW), .RD_LAT(RD_LAT), .CALC_LAT(CALC_LAT))
        dut12 (.clk(clk), .reset(reset), .bus(b12.slave));

    logic [W-1:0]  mem_a [NBLK], mem_b [NBLK];
    logic [1:0]    rsh = '0;
    logic [AW-1:0] ash [2];

    // Row data is only valid exactly RD_LAT cycles after the read strobe; garbage otherwise.
    always @(posedge clk) begin
        rsh    <= {rsh[0], b16.rd_en};
        ash[0] <= b16.rd_addr;
        ash[1] <= ash[0];
    end
    assign b16.first_row  = rsh[1] ? mem_a[ash[1]] : {NI{32'hA5A5_5A5A}};
    assign b16.second_row = rsh[1] ? mem_b[ash[1]] : {NI{32'h5A5A_A5A5}};
    assign b12.start      = b16.start;
    assign b12.op         = b16.op;
    assign b12.constant   = b16.constant;
    assign b12.first_row  = b16.first_row;
    assign b12.second_row = b16.second_row;
    assign b12.wr_ready   = b16.wr_ready;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input int op, input logic [EW-1:0] c, input int blk, input int neq);
        logic [W-1:0]  r;
        logic [EW-1:0] a, b, p;
        r = '0;
        for (int i = 0; i < NI; i++) begin
            a = mem_a[blk][i*EW +: EW];
            b = mem_b[blk][i*EW +: EW];
            p = c * b;
            if (blk * NI + i < neq)
                r[i*EW +: EW] = op == 0 ? a + b : op == 1 ? a + p : op == 2 ? a - p : p;
        end
        return r;
    endfunction

    task automatic fill_const(input logic [EW-1:0] av, input logic [EW-1:0] bv);
        for (int k = 0; k < NBLK; k++) begin
            mem_a[k] = {NI{av}};
            mem_b[k] = {NI{bv}};
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NBLK; k++)
            for (int i = 0; i < NI; i++) begin
                mem_a[k][i*EW +: EW] = $urandom;
                mem_b[k][i*EW +: EW] = $urandom;
            end
    endtask

    task automatic run_op(input int op, input logic [EW-1:0] c, input int stall_blk, input int stall_n, input bit disturb);
        int n, nwr, stalled;
        bit overlap, done;
        @(negedge clk);
        b16.start    = 1;
        b16.op       = op[1:0];
        b16.constant = c;
        b16.wr_ready = 1;
        n = 0; nwr = 0; stalled = 0; overlap = 0; done = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            b16.start = 0;
            if (disturb && n == 3) begin
                b16.start    = 1;
                b16.op       = op[1:0] + 2'd1;
                b16.constant = c + 32'd7;
            end
            if (n == 1) check("busy_after_start", b16.busy, 1);
            overlap |= (b16.rd_en && b16.wr_en) || (b12.rd_en && b12.wr_en);
            if (b16.wr_en) begin
                b16.wr_ready = !(b16.wr_addr == stall_blk && stalled < stall_n);
                if (!b16.wr_ready) stalled++;
                check("wr_data16", b16.wr_data, model(op, c, int'(b16.wr_addr), 16));
                check("wr_data12", b12.wr_data, model(op, c, int'(b12.wr_addr), 12));
                if (b16.wr_ready) begin
                    check("wr_addr", b16.wr_addr, nwr);
                    check("wr_en12", b12.wr_en, 1);
                    nwr++;
                end
            end else b16.wr_ready = 1'($urandom_range(0, 1));
            done = b16.finish;
        end
        check("finish_latency", n, NBLK * (2 + RD_LAT + CALC_LAT) + 1 + stall_n);
        check("write_count", nwr, NBLK);
        check("blk_count16", b16.blk_count, NBLK);
        check("blk_count12", b12.blk_count, NBLK);
        check("busy_at_finish", b16.busy, 0);
        check("rd_wr_overlap", overlap, 0);
        @(negedge clk);
        check("finish_one_cycle", b16.finish, 0);
        check("blk_count_hold", b16.blk_count, NBLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl16"}, {b16.rd_en, b16.wr_en, b16.busy, b16.finish, b16.rd_addr, b16.wr_addr, b16.blk_count}, 0);
        check({tag, "_ctl12"}, {b12.rd_en, b12.wr_en, b12.busy, b12.finish, b12.rd_addr, b12.wr_addr, b12.blk_count}, 0);
        check({tag, "_wdata16"}, b16.wr_data, 0);
        check({tag, "_wdata12"}, b12.wr_data, 0);
    endtask

    task automatic reset_mid_run();
        bit found, seen;
        @(negedge clk);
        b16.start    = 1;
        b16.op       = 2'd1;
        b16.constant = 32'd9;
        b16.wr_ready = 1;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            b16.start = 0;
            found = b16.rd_en && b16.rd_addr == 1'b1;
        end
        check("block1_read_seen", found, 1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check_reset_outputs("mid_reset");
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen |= b16.rd_en | b16.wr_en | b12.rd_en | b12.wr_en;
        end
        check("quiet_after_reset", seen, 0);
    endtask

    initial begin
        b16.start = 0; b16.op = 0; b16.constant = 0; b16.wr_ready = 1;
        fill_const(0, 0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 0;
        fill_const(32'd1, 32'd2);
        run_op(1, 32'd3, -1, 0, 0);
        fill_const(32'd0, 32'd1);
        run_op(2, 32'd5, -1, 0, 0);
        fill_const(32'd4, 32'd4);
        run_op(0, 32'd0, -1, 0, 0);
        fill_rand();
        run_op(3, $urandom, -1, 0, 0);
        fill_rand();
        run_op(1, $urandom, 0, 5, 0);
        fill_rand();
        run_op(2, $urandom, -1, 0, 1);
        reset_mid_run();
        fill_rand();
        run_op(1, 32'hFFFF_FFFF, -1, 0, 0);
        for (int t = 0; t < 8; t++) begin
            fill_rand();
            run_op(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
